// File: rtl/rc4_key_search.sv
// Brute-force RC4 key search: launches the decrypt chain per candidate key and
// scans decrypted RAM for lowercase/space plaintext, reporting the first hit or failure.
module rc4_key_search #(
  parameter int                   MSG_LEN   = 32,
  parameter int                   KEY_WIDTH = 24,
  parameter logic [KEY_WIDTH-1:0] KEY_START = 24'h000000,
  parameter logic [KEY_WIDTH-1:0] KEY_LIMIT = 24'h3FFFFF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 stage_fin,
  input  logic [7:0]           dec_q,
  output logic                 init_start,
  output logic [KEY_WIDTH-1:0] secret_key,
  output logic [7:0]           dec_addr,
  output logic                 dec_rd_on,
  output logic                 busy,
  output logic                 key_found,
  output logic                 key_fail,
  output logic                 done
);

  typedef enum logic [2:0] {
    S_IDLE, S_LAUNCH, S_WAIT, S_SCAN, S_NEXT, S_FOUND, S_FAIL
  } state_t;

  localparam logic [8:0] LAST_IDX = 9'(MSG_LEN);

  state_t     state;
  logic [8:0] idx;
  logic [8:0] idx_nxt;
  logic       byte_ok;

  assign idx_nxt = idx + 9'd1;
  assign byte_ok = (dec_q == 8'h20) || ((dec_q >= 8'h61) && (dec_q <= 8'h7A));

  // idx runs one past the last address: data for address idx-1 arrives in cycle idx.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      secret_key <= KEY_START;
      dec_addr   <= '0;
      idx        <= '0;
      init_start <= 1'b0;
      dec_rd_on  <= 1'b0;
      busy       <= 1'b0;
      key_found  <= 1'b0;
      key_fail   <= 1'b0;
      done       <= 1'b0;
    end else begin
      init_start <= 1'b0;
      done       <= 1'b0;
      unique case (state)
        S_IDLE: if (start) begin
          key_found  <= 1'b0;
          key_fail   <= 1'b0;
          secret_key <= KEY_START;
          busy       <= 1'b1;
          init_start <= 1'b1;
          state      <= S_LAUNCH;
        end
        S_LAUNCH: state <= S_WAIT;
        S_WAIT: if (stage_fin) begin
          idx       <= '0;
          dec_addr  <= '0;
          dec_rd_on <= 1'b1;
          state     <= S_SCAN;
        end
        S_SCAN: begin
          if ((idx != 9'd0) && !byte_ok) begin
            dec_rd_on <= 1'b0;
            state     <= S_NEXT;
          end else if (idx == LAST_IDX) begin
            dec_rd_on <= 1'b0;
            key_found <= 1'b1;
            done      <= 1'b1;
            state     <= S_FOUND;
          end else begin
            idx      <= idx_nxt;
            dec_addr <= idx_nxt[7:0];
          end
        end
        // Limit test before increment, so the key never wraps.
        S_NEXT: begin
          if (secret_key == KEY_LIMIT) begin
            key_fail <= 1'b1;
            done     <= 1'b1;
            state    <= S_FAIL;
          end else begin
            secret_key <= secret_key + KEY_WIDTH'(1);
            init_start <= 1'b1;
            state      <= S_LAUNCH;
          end
        end
        S_FOUND, S_FAIL: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
